profile_ci_multi: RTL

Parametrised performance-counter custom instruction, successor to the fixed 4×32-bit profiling CI.
- NUM_COUNTERS counters of COUNTER_WIDTH bits, each counting any one of NUM_EVENTS event inputs, in level or rising-edge mode.
- Global run/stop and atomic reads of counters wider than 32 bits through a high-half shadow register.
- Sits on the CPU custom-instruction port beside other CI blocks; events are wired from core, bus and accelerator status signals.

---
 rtl/profile_ci_multi.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/profile_ci_multi.sv
// profile_ci_multi -- parametrised performance-counter custom instruction.
//
// NUM_COUNTERS counters of COUNTER_WIDTH bits. Each counter watches one of
// the NUM_EVENTS event inputs, either as a level or as a rising edge. Counters
// are gated by a global run bit. A counter wider than 32 bits is read
// atomically: READ_LO returns the low word and, in the same cycle, copies the
// high part into a shadow register that READ_HI returns later.
//
// Optional feature, macro PROFILE_CI_OVERFLOW_EN:
//   defined   -> sticky per-counter overflow flags, READ_OVF / CLR_OVF opcodes,
//                registered overflowIrq = OR of the flags.
//   undefined -> no flag storage, opcodes 5/6 return 0, overflowIrq = 0.
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-high reset
//   start        CI start pulse
//   cIn          CI id; the block answers only when cIn == customId
//   valueA       [2:0] opcode, [6:4] counter index
//   valueB       operand
//   events       event sources, sampled every clock
//   done         registered completion, one cycle after an accepted start
//   result       registered result, zero whenever done is low
//   overflowIrq  OR of the sticky overflow flags (0 without the macro)
module profile_ci_multi #(
    parameter logic [7:0] customId      = 8'h00,
    parameter int         NUM_COUNTERS  = 4,
    parameter int         COUNTER_WIDTH = 48,
    parameter int         NUM_EVENTS    = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            cIn,
    input  logic [31:0]           valueA,
    input  logic [31:0]           valueB,
    input  logic [NUM_EVENTS-1:0] events,
    output logic                  done,
    output logic [31:0]           result,
    output logic                  overflowIrq
);

    localparam logic [2:0] OP_READ_LO    = 3'd0;
    localparam logic [2:0] OP_READ_HI    = 3'd1;
    localparam logic [2:0] OP_WRITE_CTRL = 3'd2;
    localparam logic [2:0] OP_GLOBAL     = 3'd3;
    localparam logic [2:0] OP_READ_CTRL  = 3'd4;
`ifdef PROFILE_CI_OVERFLOW_EN
    localparam logic [2:0] OP_READ_OVF   = 3'd5;
    localparam logic [2:0] OP_CLR_OVF    = 3'd6;
`endif

    logic                     accept;
    logic [2:0]               op;
    logic [2:0]               idx;
    logic                     idx_ok;
    logic [15:0]              ev_ext;
    logic [15:0]              prev_ext;
    logic [NUM_EVENTS-1:0]    prev_q;
    logic                     glob_en_q, glob_en_d;
    logic [31:0]              shadow_q, shadow_d;
    logic                     done_q;
    logic [31:0]              result_q;
    logic [31:0]              resp;
    logic [COUNTER_WIDTH-1:0] cnt_vec  [8];
    logic [5:0]               ctrl_vec [8];
    logic                     unused_bits;
`ifdef PROFILE_CI_OVERFLOW_EN
    logic [7:0]               wrap_vec;
    logic [7:0]               ovf_q, ovf_d;
    logic                     irq_q;
`endif

    assign accept = start && (cIn == customId);
    assign op     = valueA[2:0];
    assign idx    = valueA[6:4];
    assign idx_ok = (int'(idx) < NUM_COUNTERS);

    // Events are zero-padded to 16 so that any 4-bit select is a legal index;
    // selects beyond NUM_EVENTS land on a constant 0 and never hit.
    assign ev_ext   = 16'(events);
    assign prev_ext = 16'(prev_q);

    assign unused_bits = ^{valueA[31:7], valueA[3], valueB[31:16], valueB[7:6]};

    // Eight slots are always generated so the 3-bit index can address the
    // read muxes directly; slots past NUM_COUNTERS read as zero.
    for (genvar i = 0; i < 8; i++) begin : g_cnt
        if (i < NUM_COUNTERS) begin : g_on
            logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
            logic [5:0]               ctrl_q, ctrl_d;   // {mode, sel[3:0], en}
            logic                     wr_ctrl;
            logic                     clr;
            logic                     hit;
            logic                     inc;

            assign wr_ctrl = accept && (op == OP_WRITE_CTRL) && (idx == 3'(i));
            assign clr     = (wr_ctrl && valueB[8])
                          || (accept && (op == OP_GLOBAL) && valueB[8+i]);
            // Edge mode additionally requires the selected event to have been
            // low in the previous cycle.
            assign hit     = ev_ext[ctrl_q[4:1]]
                          && (!ctrl_q[5] || !prev_ext[ctrl_q[4:1]]);
            // Uses the registered config, so a write only affects later cycles.
            assign inc     = glob_en_q && ctrl_q[0] && hit;

            always_comb begin
                cnt_d = cnt_q;
                if (clr) begin
                    cnt_d = '0;
                end else if (inc) begin
                    cnt_d = cnt_q + COUNTER_WIDTH'(1);
                end
                ctrl_d = wr_ctrl ? valueB[5:0] : ctrl_q;
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    cnt_q  <= '0;
                    ctrl_q <= '0;
                end else begin
                    cnt_q  <= cnt_d;
                    ctrl_q <= ctrl_d;
                end
            end

            assign cnt_vec[i]  = cnt_q;
            assign ctrl_vec[i] = ctrl_q;
`ifdef PROFILE_CI_OVERFLOW_EN
            // A clear in the same cycle wins, so the counter does not wrap.
            assign wrap_vec[i] = inc && !clr && (&cnt_q);
`endif
        end else begin : g_off
            assign cnt_vec[i]  = '0;
            assign ctrl_vec[i] = '0;
`ifdef PROFILE_CI_OVERFLOW_EN
            assign wrap_vec[i] = 1'b0;
`endif
        end
    end

    // Response and global/shadow next state; values are pre-increment.
    always_comb begin
        resp      = '0;
        shadow_d  = shadow_q;
        glob_en_d = glob_en_q;
        if (accept) begin
            case (op)
                OP_READ_LO: begin
                    if (idx_ok) begin
                        resp     = cnt_vec[idx][31:0];
                        shadow_d = 32'(cnt_vec[idx][COUNTER_WIDTH-1:32]);
                    end
                end
                OP_READ_HI:   resp = shadow_q;
                OP_GLOBAL:    glob_en_d = valueB[0];
                OP_READ_CTRL: begin
                    if (idx_ok) begin
                        resp = {26'd0, ctrl_vec[idx]};
                    end
                end
`ifdef PROFILE_CI_OVERFLOW_EN
                OP_READ_OVF:  resp = {24'd0, ovf_q};
`endif
                default:      resp = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            done_q    <= 1'b0;
            result_q  <= '0;
            shadow_q  <= '0;
            glob_en_q <= 1'b0;
            prev_q    <= '0;
        end else begin
            done_q    <= accept;
            result_q  <= resp;
            shadow_q  <= shadow_d;
            glob_en_q <= glob_en_d;
            prev_q    <= events;
        end
    end

`ifdef PROFILE_CI_OVERFLOW_EN
    // Clear first, then OR in new wraps so a same-cycle set wins.
    always_comb begin
        ovf_d = ovf_q;
        if (accept && (op == OP_CLR_OVF)) begin
            ovf_d = ovf_d & ~valueB[7:0];
        end
        ovf_d = ovf_d | wrap_vec;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_q <= '0;
            irq_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            irq_q <= |ovf_d;
        end
    end

    assign overflowIrq = irq_q;
`else
    assign overflowIrq = 1'b0;
`endif

    assign done   = done_q;
    assign result = result_q;

endmodule
